muxpga_cfg_loader: RTL and testbench
====================================

MUXPGA_CFG_LOADER -- requirements
Module: muxpga_cfg_loader

Interface
REQ-001 SHALL have parameter NIBBLES, default 24, giving the configuration chain depth in 4-bit nibbles.
REQ-002 SHALL have port clk  input  1  rising-edge clock, shared with the fabric.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_en  input  1  image-write strobe.
REQ-005 SHALL have port wr_addr  input  5  image address, 0..NIBBLES-1.
REQ-006 SHALL have port wr_data  input  4  image nibble.
REQ-007 SHALL have port start  input  1  begin the program sequence.
REQ-008 SHALL have port stop  input  1  leave run mode.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE and RUN.
REQ-010 SHALL have port running  output  1  high in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse on entry to RUN.
REQ-012 SHALL have port err  output  1  sticky readback-mismatch flag.
REQ-013 SHALL have port fab_rst  output  1  drives the fabric reset pin.
REQ-014 SHALL have port fab_cmd  output  2  drives the fabric cmd pins.
REQ-015 SHALL have port fab_nibble  output  4  drives the fabric nibble pins.
REQ-016 SHALL have port fab_rdbk  input  4  fabric io_out[7:4], the chain-tail nibble.

Function
REQ-017 SHALL hold a NIBBLES x 4 image register array; wr_en writes wr_data to wr_addr only in IDLE or RUN, and only when wr_addr < NIBBLES.
REQ-018 SHALL register all fab_* outputs and SHALL drive fab_cmd as follows: 00 = shift, 01 = run, 10 = hold.
REQ-019 SHALL implement the states IDLE, CLR, SHIFT, VERIFY and RUN.
REQ-020 IDLE: fab_cmd=10, fab_rst=0; start moves the FSM to CLR.
REQ-021 CLR: lasts one cycle with fab_rst=1 and fab_cmd=10, then moves to SHIFT with the index at 0.
REQ-022 SHIFT: lasts NIBBLES cycles; in cycle k the block drives fab_cmd=00 and fab_nibble=image[k], k=0..NIBBLES-1.
REQ-023 After SHIFT, image[a] resides in fabric chain position NIBBLES-1-a.
REQ-024 After the last SHIFT cycle, the FSM goes to VERIFY when enabled (REQ-034), otherwise to RUN.
REQ-025 RUN: fab_cmd=01; stop moves the FSM to IDLE; start is ignored in RUN.
REQ-026 done SHALL pulse high for exactly the first RUN cycle.
REQ-027 start and stop SHALL be ignored while busy; stop SHALL be ignored in IDLE.
REQ-028 A programming sequence from start to the first RUN cycle SHALL take 1+NIBBLES cycles without readback, or 1+2*NIBBLES cycles with it.
REQ-029 err SHALL be cleared on entry to CLR and held otherwise, except as set in REQ-034.
REQ-030 Writes to the image during busy SHALL be dropped.

Reset
REQ-031 Reset SHALL override all other inputs, including mid-sequence, and SHALL return the FSM to IDLE within one cycle.
REQ-032 Reset values: busy=0, running=0, done=0, err=0, fab_rst=1, fab_cmd=10, fab_nibble=0; fab_rst returns to 0 on the first cycle after reset deasserts.
REQ-033 The image array SHALL NOT be reset; its contents SHALL be retained across reset.

Configuration
REQ-034 When macro MUXPGA_CFG_READBACK_EN is defined, the VERIFY state SHALL exist:
- lasts NIBBLES cycles, re-shifting image[k] with fab_cmd=00;
- in the same cycle, compares fab_rdbk with image[k];
- any mismatch sets err;
- the FSM enters RUN regardless of err;
- the fabric chain holds the image again afterwards.
REQ-035 When MUXPGA_CFG_READBACK_EN is undefined, VERIFY and its comparator SHALL be absent, err SHALL be tied to 0, and fab_rdbk SHALL be unused.

Verification
REQ-036 Write image[a]=a[3:0] for all a, pulse start -> fab_rst=1 for 1 cycle, then 24 cycles of cmd=00 with nibble 0,1,..,F,0,..,7, then cmd=01 and done=1 for 1 cycle.
REQ-037 With readback enabled and a fabric model attached, load image 5,A,5,A.. -> err=0, RUN entered 49 cycles after start, and fabric chain position 23 holds 5.
REQ-038 Readback enabled, fabric model forces chain position 10 to the wrong value -> err=1 in the VERIFY cycle where k=13, RUN still entered, and err clears on the next start.
REQ-039 Assert reset at SHIFT k=7 -> next cycle busy=0, fab_cmd=10, fab_rst=1; a subsequent start restarts from nibble 0.
REQ-040 Pulse start during SHIFT, and wr_en with data F at address 3 during SHIFT -> no restart, and image[3] unchanged.
REQ-041 In RUN, pulse stop -> next cycle fab_cmd=10, running=0; a further stop in IDLE has no effect.

Source files
------------

// File: rtl/muxpga_cfg_loader.sv
// muxpga_cfg_loader: holds a NIBBLES x 4 configuration image and streams it into the
// fabric's 4-bit-wide configuration shift chain, then releases the fabric into run mode.
// Optional feature: define MUXPGA_CFG_READBACK_EN to add a VERIFY pass that re-shifts
// the image while comparing the chain tail (fab_rdbk) against it, raising a sticky err.
module muxpga_cfg_loader #(
    parameter int unsigned NIBBLES = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       start,
    input  logic       stop,
    output logic       busy,
    output logic       running,
    output logic       done,
    output logic       err,
    output logic       fab_rst,
    output logic [1:0] fab_cmd,
    output logic [3:0] fab_nibble,
    input  logic [3:0] fab_rdbk
);

    localparam logic [4:0] LastIdx = 5'(NIBBLES - 1);

    localparam logic [1:0] CmdShift = 2'b00;
    localparam logic [1:0] CmdRun   = 2'b01;
    localparam logic [1:0] CmdHold  = 2'b10;

`ifdef MUXPGA_CFG_READBACK_EN
    typedef enum logic [2:0] {StIdle, StClr, StShift, StVerify, StRun} state_e;
`else
    typedef enum logic [2:0] {StIdle, StClr, StShift, StRun} state_e;
`endif

    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       fab_rst_q, fab_rst_d;
    logic [1:0] fab_cmd_q, fab_cmd_d;
    logic [3:0] fab_nibble_q, fab_nibble_d;
    logic       img_we;

    logic [3:0] image_q [NIBBLES];

`ifdef MUXPGA_CFG_READBACK_EN
    logic err_q, err_d;
`endif

    // Image writes are accepted only while the chain is not being driven from the image
    always_comb begin
        img_we = wr_en && !reset && ((state_q == StIdle) || (state_q == StRun)) &&
                 ({27'd0, wr_addr} < NIBBLES);
    end

    // Image store has no reset so a reset never loses the loaded configuration
    always_ff @(posedge clk) begin
        if (img_we) begin
            image_q[wr_addr] <= wr_data;
        end
    end

    // Next-state logic; fab_* outputs are derived from the next state so they line up
    // with the state they belong to once registered
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
`ifdef MUXPGA_CFG_READBACK_EN
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClr;
                    idx_d   = 5'd0;
`ifdef MUXPGA_CFG_READBACK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            StClr: begin
                state_d = StShift;
                idx_d   = 5'd0;
            end
            StShift: begin
                if (idx_q == LastIdx) begin
                    idx_d   = 5'd0;
`ifdef MUXPGA_CFG_READBACK_EN
                    state_d = StVerify;
`else
                    state_d = StRun;
`endif
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
`ifdef MUXPGA_CFG_READBACK_EN
            StVerify: begin
                // Chain tail during re-shift cycle k carries the nibble loaded as image[k]
                if (fab_rdbk != image_q[idx_q]) begin
                    err_d = 1'b1;
                end
                if (idx_q == LastIdx) begin
                    idx_d   = 5'd0;
                    state_d = StRun;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
`endif
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (reset) begin
            state_d = StIdle;
            idx_d   = 5'd0;
`ifdef MUXPGA_CFG_READBACK_EN
            err_d   = 1'b0;
`endif
        end

        busy_d       = (state_d != StIdle) && (state_d != StRun);
        running_d    = (state_d == StRun);
        done_d       = (state_d == StRun) && (state_q != StRun) && !reset;
        fab_rst_d    = reset || (state_d == StClr);
        fab_cmd_d    = CmdHold;
        fab_nibble_d = 4'd0;
        if (state_d == StRun) begin
            fab_cmd_d = CmdRun;
        end
        if (state_d == StShift
`ifdef MUXPGA_CFG_READBACK_EN
            || state_d == StVerify
`endif
           ) begin
            fab_cmd_d    = CmdShift;
            fab_nibble_d = image_q[idx_d];
        end
        if (reset) begin
            fab_cmd_d = CmdHold;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        state_q      <= state_d;
        idx_q        <= idx_d;
        busy_q       <= busy_d;
        running_q    <= running_d;
        done_q       <= done_d;
        fab_rst_q    <= fab_rst_d;
        fab_cmd_q    <= fab_cmd_d;
        fab_nibble_q <= fab_nibble_d;
`ifdef MUXPGA_CFG_READBACK_EN
        err_q        <= err_d;
`endif
    end

    assign busy       = busy_q;
    assign running    = running_q;
    assign done       = done_q;
    assign fab_rst    = fab_rst_q;
    assign fab_cmd    = fab_cmd_q;
    assign fab_nibble = fab_nibble_q;

`ifdef MUXPGA_CFG_READBACK_EN
    assign err = err_q;
`else
    logic unused_rdbk;
    assign err         = 1'b0;
    assign unused_rdbk = ^fab_rdbk;
`endif

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// Bench for muxpga_cfg_loader: random images checked cycle-by-cycle against a
// sequence model derived from the programming rules, plus a shift-chain fabric model.
module tb_muxpga_cfg_loader;

    localparam int N        = 24;
    localparam int FORCE_POS = 10;
    localparam int ERR_K    = N - 1 - FORCE_POS;
`ifdef MUXPGA_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic       start;
    logic       stop;
    logic       busy;
    logic       running;
    logic       done;
    logic       err;
    logic       fab_rst;
    logic [1:0] fab_cmd;
    logic [3:0] fab_nibble;
    logic [3:0] fab_rdbk;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] img_m [N];
    logic [3:0] chain [N];
    int         shift_cnt;
    bit         corrupt_en;

    muxpga_cfg_loader #(.NIBBLES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .running    (running),
        .done       (done),
        .err        (err),
        .fab_rst    (fab_rst),
        .fab_cmd    (fab_cmd),
        .fab_nibble (fab_nibble),
        .fab_rdbk   (fab_rdbk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fabric: reset clears the chain, cmd 00 shifts a nibble in at position 0.
    // Optionally disturbs position FORCE_POS right after the N-th shift.
    assign fab_rdbk = chain[N-1];
    always @(posedge clk) begin
        if (fab_rst) begin
            for (int i = 0; i < N; i++) chain[i] <= 4'd0;
            shift_cnt <= 0;
        end else if (fab_cmd == 2'b00) begin
            chain[0] <= fab_nibble;
            for (int i = 1; i < N; i++) chain[i] <= chain[i-1];
            if (corrupt_en && shift_cnt == N - 1)
                chain[FORCE_POS] <= chain[FORCE_POS-1] ^ 4'h5;
            shift_cnt <= shift_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_img(input int addr, input logic [3:0] data);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        if (addr < N) img_m[addr] = data;
    endtask

    task automatic check_chain();
        for (int p = 0; p < N; p++) check_val("chain", {28'd0, chain[p]}, {28'd0, img_m[N-1-p]});
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("stop_cmd", {30'd0, fab_cmd}, 32'd2);
        check_val("stop_running", {31'd0, running}, 32'd0);
        check_val("stop_busy", {31'd0, busy}, 32'd0);
    endtask

    // One programming sequence from the start pulse to the first RUN cycles.
    task automatic program_seq(input bit corrupt, input int disturb_k, input int abort_k);
        int total;
        int k;
        bit exp_err;
        total = RB ? 1 + 2 * N : 1 + N;
        corrupt_en = corrupt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= total; c++) begin
            k = (c - 2) % N;
            exp_err = RB && corrupt && (c >= N + 2) && (k > ERR_K);
            check_val("seq_busy", {31'd0, busy}, 32'd1);
            check_val("seq_running", {31'd0, running}, 32'd0);
            check_val("seq_done", {31'd0, done}, 32'd0);
            check_val("seq_err", {31'd0, err}, {31'd0, exp_err});
            if (c == 1) begin
                check_val("clr_rst", {31'd0, fab_rst}, 32'd1);
                check_val("clr_cmd", {30'd0, fab_cmd}, 32'd2);
            end else begin
                check_val("sh_rst", {31'd0, fab_rst}, 32'd0);
                check_val("sh_cmd", {30'd0, fab_cmd}, 32'd0);
                check_val("sh_nibble", {28'd0, fab_nibble}, {28'd0, img_m[k]});
            end
            if (c >= 2 && c <= N + 1 && k == abort_k) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_val("abort_busy", {31'd0, busy}, 32'd0);
                check_val("abort_cmd", {30'd0, fab_cmd}, 32'd2);
                check_val("abort_rst", {31'd0, fab_rst}, 32'd1);
                check_val("abort_running", {31'd0, running}, 32'd0);
                tick();
                check_val("abort_rst_release", {31'd0, fab_rst}, 32'd0);
                return;
            end
            if (c >= 2 && c <= N + 1 && k == disturb_k) begin
                start   = 1'b1;
                stop    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 5'd3;
                wr_data = ~img_m[3];
            end
            tick();
            start = 1'b0;
            stop  = 1'b0;
            wr_en = 1'b0;
        end
        check_val("run_running", {31'd0, running}, 32'd1);
        check_val("run_done", {31'd0, done}, 32'd1);
        check_val("run_cmd", {30'd0, fab_cmd}, 32'd1);
        check_val("run_busy", {31'd0, busy}, 32'd0);
        check_val("run_err", {31'd0, err}, {31'd0, RB && corrupt});
        tick();
        check_val("run_done_pulse", {31'd0, done}, 32'd0);
        check_val("run_hold", {31'd0, running}, 32'd1);
        corrupt_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        wr_addr = 5'd0;
        wr_data = 4'd0;
        start = 1'b0;
        stop = 1'b0;
        corrupt_en = 1'b0;
        repeat (3) tick();
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_running", {31'd0, running}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_fab_rst", {31'd0, fab_rst}, 32'd1);
        check_val("rst_cmd", {30'd0, fab_cmd}, 32'd2);
        check_val("rst_nibble", {28'd0, fab_nibble}, 32'd0);
        reset = 1'b0;
        tick();
        check_val("rel_fab_rst", {31'd0, fab_rst}, 32'd0);
        check_val("rel_cmd", {30'd0, fab_cmd}, 32'd2);

        // Counting image, plus writes beyond the array that must be ignored
        for (int a = 0; a < N; a++) write_img(a, 4'(a));
        for (int a = N; a < 32; a++) write_img(a, 4'($urandom));
        program_seq(1'b0, -1, -1);
        check_chain();

        // Writes are allowed in RUN; stop returns to IDLE, a second stop does nothing
        write_img($urandom_range(0, N - 1), 4'($urandom));
        write_img($urandom_range(0, N - 1), 4'($urandom));
        pulse_stop();
        pulse_stop();
        check_val("idle_rst", {31'd0, fab_rst}, 32'd0);

        // start/stop/write during SHIFT are ignored
        program_seq(1'b0, 3, -1);
        check_chain();
        pulse_stop();

        // Reset in the middle of SHIFT, then a clean restart
        program_seq(1'b0, -1, 7);
        program_seq(1'b0, -1, -1);
        check_chain();
        pulse_stop();

        // Random images with random (partly out-of-range) addresses
        repeat (4) begin
            repeat (12) write_img($urandom_range(0, 31), 4'($urandom));
            program_seq(1'b0, -1, -1);
            check_chain();
            pulse_stop();
        end

        if (RB) begin
            for (int a = 0; a < N; a++) write_img(a, (a % 2 == 0) ? 4'h5 : 4'hA);
            program_seq(1'b0, -1, -1);
            check_val("rb_tail", {28'd0, chain[N-1]}, 32'h5);
            check_chain();
            pulse_stop();
            program_seq(1'b1, -1, -1);
            check_chain();
            pulse_stop();
            program_seq(1'b0, -1, -1);
            pulse_stop();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
